// File: rtl/mem_port_arbiter.sv
// Arbitrates the mem_mgr data port between the CPU load/store stage, which has
// priority, and a debug/loader master. A starvation counter guarantees the debug
// master forward progress. Debug responses come back one cycle after the grant.
module mem_port_arbiter #(
  parameter int WIDTH        = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             cpu_we,
  input  logic             cpu_re,
  input  logic [WIDTH-1:0] cpu_wr_addr,
  input  logic [WIDTH-1:0] cpu_rd_addr,
  input  logic [2:0]       cpu_wr_bytes,
  input  logic [2:0]       cpu_rd_bytes,
  input  logic [WIDTH-1:0] cpu_wr_data,
  input  logic             cpu_rd_unsigned,
  output logic             cpu_stall,
  input  logic             dbg_valid,
  output logic             dbg_ready,
  input  logic             dbg_write,
  input  logic [WIDTH-1:0] dbg_addr,
  input  logic [2:0]       dbg_bytes,
  input  logic             dbg_unsigned,
  input  logic [WIDTH-1:0] dbg_wdata,
  output logic             dbg_rvalid,
  output logic [WIDTH-1:0] dbg_rdata,
  output logic             dbg_err,
  output logic             mem_we,
  output logic             mem_re,
  output logic [WIDTH-1:0] mem_wr_addr,
  output logic [WIDTH-1:0] mem_rd_addr,
  output logic [2:0]       mem_wr_bytes,
  output logic [2:0]       mem_rd_bytes,
  output logic [WIDTH-1:0] mem_wr_data,
  output logic             mem_rd_unsigned,
  input  logic [WIDTH-1:0] mem_rd_data,
  input  logic             mem_must_wait
);

  localparam int LOG2B = $clog2(WIDTH / 8);
  localparam int CW    = $clog2(STARVE_LIMIT + 1);

  // state | meaning
  // IDLE  | CPU owns the port; debug may be granted this cycle
  // RESP  | debug response cycle; CPU owns the port, no debug grant
  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_starve_cnt;
  logic             r_dbg_rvalid;
  logic             r_dbg_err;
  logic             r_good_rd;
  logic [WIDTH-1:0] r_rdata_hold;

  logic             w_cpu_req;
  logic [3:0]       w_align_mask;
  logic             w_dbg_err;
  logic             w_grant;
  logic [WIDTH-1:0] w_resp_rdata;

  assign w_cpu_req = cpu_re | cpu_we;

  // Low address bits that must be zero for the requested access size.
  always_comb begin
    w_align_mask = 4'b1111;
    case (dbg_bytes)
      3'd0:    w_align_mask = 4'b0000;
      3'd1:    w_align_mask = 4'b0001;
      3'd2:    w_align_mask = 4'b0011;
      3'd3:    w_align_mask = 4'b0111;
      default: w_align_mask = 4'b1111;
    endcase
  end

  assign w_dbg_err = (dbg_bytes > 3'(LOG2B)) | (|(dbg_addr[3:0] & w_align_mask));

  assign w_grant = clr_n & (r_state == IDLE) & dbg_valid & ~mem_must_wait &
                   (~w_cpu_req | (r_starve_cnt == CW'(STARVE_LIMIT)));

  assign w_resp_rdata = r_good_rd ? mem_rd_data : '0;

  assign dbg_ready  = w_grant;
  assign cpu_stall  = ~clr_n | mem_must_wait | (w_grant & w_cpu_req);
  assign dbg_rvalid = r_dbg_rvalid;
  assign dbg_err    = r_dbg_err;
  // mem_rd_data is only valid in the response cycle, so pass it through then and hold it afterwards.
  assign dbg_rdata  = r_dbg_rvalid ? w_resp_rdata : r_rdata_hold;

  // Port mux: CPU passes through unless debug is granted; enables are forced off in reset.
  always_comb begin
    mem_we          = cpu_we & clr_n;
    mem_re          = cpu_re & clr_n;
    mem_wr_addr     = cpu_wr_addr;
    mem_rd_addr     = cpu_rd_addr;
    mem_wr_bytes    = cpu_wr_bytes;
    mem_rd_bytes    = cpu_rd_bytes;
    mem_wr_data     = cpu_wr_data;
    mem_rd_unsigned = cpu_rd_unsigned;
    if (w_grant) begin
      mem_we          = dbg_write & ~w_dbg_err;
      mem_re          = ~dbg_write & ~w_dbg_err;
      mem_wr_addr     = dbg_addr;
      mem_rd_addr     = dbg_addr;
      mem_wr_bytes    = dbg_bytes;
      mem_rd_bytes    = dbg_bytes;
      mem_wr_data     = dbg_wdata;
      mem_rd_unsigned = dbg_unsigned;
    end
  end

  // FSM, response registers and starvation counter.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state      <= IDLE;
      r_starve_cnt <= '0;
      r_dbg_rvalid <= 1'b0;
      r_dbg_err    <= 1'b0;
      r_good_rd    <= 1'b0;
      r_rdata_hold <= '0;
    end else begin
      case (r_state)
        IDLE:    if (w_grant) r_state <= RESP;
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
      r_dbg_rvalid <= w_grant;
      if (w_grant) begin
        r_dbg_err <= w_dbg_err;
        r_good_rd <= ~dbg_write & ~w_dbg_err;
      end
      if (r_dbg_rvalid) r_rdata_hold <= w_resp_rdata;
      if (!dbg_valid || w_grant) begin
        r_starve_cnt <= '0;
      end else if (!mem_must_wait && w_cpu_req && (r_starve_cnt != CW'(STARVE_LIMIT))) begin
        r_starve_cnt <= r_starve_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, directed corner sequences and a
// randomized phase checked against a cycle-level behavioural model.
module tb_mem_port_arbiter;
  localparam int W   = 32;
  localparam int LIM = 4;

  logic         clk = 1'b0;
  logic         clr_n;
  logic         cpu_we, cpu_re, cpu_rd_unsigned, cpu_stall;
  logic [W-1:0] cpu_wr_addr, cpu_rd_addr, cpu_wr_data;
  logic [2:0]   cpu_wr_bytes, cpu_rd_bytes;
  logic         dbg_valid, dbg_ready, dbg_write, dbg_unsigned, dbg_rvalid, dbg_err;
  logic [W-1:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic [2:0]   dbg_bytes;
  logic         mem_we, mem_re, mem_rd_unsigned, mem_must_wait;
  logic [W-1:0] mem_wr_addr, mem_rd_addr, mem_wr_data, mem_rd_data;
  logic [2:0]   mem_wr_bytes, mem_rd_bytes;

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(.WIDTH(W), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .clr_n(clr_n),
    .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_wr_addr(cpu_wr_addr), .cpu_rd_addr(cpu_rd_addr),
    .cpu_wr_bytes(cpu_wr_bytes), .cpu_rd_bytes(cpu_rd_bytes), .cpu_wr_data(cpu_wr_data),
    .cpu_rd_unsigned(cpu_rd_unsigned), .cpu_stall(cpu_stall),
    .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_write(dbg_write), .dbg_addr(dbg_addr),
    .dbg_bytes(dbg_bytes), .dbg_unsigned(dbg_unsigned), .dbg_wdata(dbg_wdata),
    .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
    .mem_we(mem_we), .mem_re(mem_re), .mem_wr_addr(mem_wr_addr), .mem_rd_addr(mem_rd_addr),
    .mem_wr_bytes(mem_wr_bytes), .mem_rd_bytes(mem_rd_bytes), .mem_wr_data(mem_wr_data),
    .mem_rd_unsigned(mem_rd_unsigned), .mem_rd_data(mem_rd_data), .mem_must_wait(mem_must_wait)
  );

  always #5 clk = ~clk;

  // Simple byte memory standing in for mem_mgr (256 bytes, wrap-around).
  logic [7:0] mem [256];

  function automatic logic [W-1:0] ld(input logic [W-1:0] a, input logic [2:0] b, input logic uns);
    logic [W-1:0] r;
    int n;
    r = '0;
    n = (b > 3'd2) ? 4 : (1 << b);
    for (int i = 0; i < n; i++) r[8*i +: 8] = mem[8'(a[7:0] + 8'(i))];
    if (!uns && n < 4 && r[8*n-1]) r = r | ~((32'd1 << (8*n)) - 32'd1);
    return r;
  endfunction

  always @(posedge clk) begin
    if (!mem_must_wait) begin
      if (mem_re) mem_rd_data <= ld(mem_rd_addr, mem_rd_bytes, mem_rd_unsigned);
      if (mem_we)
        for (int i = 0; i < 4 && i < (1 << mem_wr_bytes); i++)
          mem[8'(mem_wr_addr[7:0] + 8'(i))] = mem_wr_data[8*i +: 8];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic zero_in;
    cpu_we = 0; cpu_re = 0; cpu_wr_addr = '0; cpu_rd_addr = '0; cpu_wr_bytes = 3'd2;
    cpu_rd_bytes = 3'd2; cpu_wr_data = '0; cpu_rd_unsigned = 0;
    dbg_valid = 0; dbg_write = 0; dbg_addr = '0; dbg_bytes = 3'd2; dbg_unsigned = 0;
    dbg_wdata = '0; mem_must_wait = 0;
  endtask

  task automatic set_dbg(input logic wr, input logic [W-1:0] a, input logic [2:0] b, input logic [W-1:0] d);
    dbg_valid = 1; dbg_write = wr; dbg_addr = a; dbg_bytes = b; dbg_wdata = d;
  endtask

  // Read via debug port with CPU idle, check the response data.
  task automatic dbg_read_expect(input string nm, input logic [W-1:0] a, input logic [W-1:0] exp);
    set_dbg(0, a, 3'd2, '0);
    #1 chk({nm, "_ready"}, dbg_ready, 1);
    tick;
    dbg_valid = 0;
    chk({nm, "_rvalid"}, dbg_rvalid, 1);
    chk({nm, "_rdata"}, dbg_rdata, exp);
    tick;
  endtask

  typedef struct {
    logic       cre, cwe, mmw, dv, dw;
    logic [7:0] addr;
    logic [2:0] bytes;
    logic       e_rdy, e_stall, e_re, e_we, e_err;
  } vec_t;

  vec_t vt[12];

  // Random-phase model state
  bit           m_resp, m_grant, m_cpu, m_err, m_good;
  int           m_blk;
  logic [W-1:0] m_exp_rd, m_last_rd;
  bit           m_exp_err, m_last_err, m_exp_re, m_exp_we;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem_rd_data = '0;
    zero_in();
    clr_n = 0;
    // Reset: outputs gated even with active requests
    dbg_valid = 1; cpu_re = 1; cpu_we = 1;
    #2;
    chk("rst_ready", dbg_ready, 0);
    chk("rst_mem_re", mem_re, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_stall", cpu_stall, 1);
    chk("rst_rvalid", dbg_rvalid, 0);
    chk("rst_err", dbg_err, 0);
    chk("rst_rdata", dbg_rdata, 0);
    zero_in();
    repeat (2) @(posedge clk);
    #1 clr_n = 1;
    #1 chk("rel_stall", cpu_stall, 0);
    tick;

    //            cre cwe mmw dv dw  addr   bytes rdy stl re we err
    vt[0]  = '{0, 0, 0, 1, 0, 8'h10, 3'd2, 1, 0, 1, 0, 0};
    vt[1]  = '{1, 0, 0, 1, 0, 8'h10, 3'd2, 0, 0, 1, 0, 0};
    vt[2]  = '{0, 1, 0, 1, 1, 8'h10, 3'd2, 0, 0, 0, 1, 0};
    vt[3]  = '{0, 0, 1, 1, 0, 8'h10, 3'd2, 0, 1, 0, 0, 0};
    vt[4]  = '{1, 0, 1, 0, 0, 8'h10, 3'd2, 0, 1, 1, 0, 0};
    vt[5]  = '{0, 0, 0, 1, 1, 8'h21, 3'd1, 1, 0, 0, 0, 1};
    vt[6]  = '{0, 0, 0, 1, 0, 8'h23, 3'd0, 1, 0, 1, 0, 0};
    vt[7]  = '{0, 0, 0, 1, 0, 8'h24, 3'd3, 1, 0, 0, 0, 1};
    vt[8]  = '{0, 0, 0, 1, 1, 8'h08, 3'd2, 1, 0, 0, 1, 0};
    vt[9]  = '{0, 0, 0, 1, 0, 8'h02, 3'd1, 1, 0, 1, 0, 0};
    vt[10] = '{1, 1, 0, 0, 0, 8'h00, 3'd2, 0, 0, 1, 1, 0};
    vt[11] = '{0, 0, 0, 1, 1, 8'h06, 3'd2, 1, 0, 0, 0, 1};

    for (int k = 0; k < 12; k++) begin
      cpu_re = vt[k].cre; cpu_we = vt[k].cwe; cpu_rd_addr = 32'h40; cpu_wr_addr = 32'h80;
      cpu_wr_data = 32'hA5A5_0000 + 32'(k); mem_must_wait = vt[k].mmw;
      dbg_valid = vt[k].dv; dbg_write = vt[k].dw; dbg_addr = {24'h0, vt[k].addr};
      dbg_bytes = vt[k].bytes; dbg_wdata = 32'h0BAD_0000 + 32'(k);
      #1;
      chk($sformatf("vec%0d_ready", k), dbg_ready, vt[k].e_rdy);
      chk($sformatf("vec%0d_stall", k), cpu_stall, vt[k].e_stall);
      chk($sformatf("vec%0d_mem_re", k), mem_re, vt[k].e_re);
      chk($sformatf("vec%0d_mem_we", k), mem_we, vt[k].e_we);
      tick;
      chk($sformatf("vec%0d_rvalid", k), dbg_rvalid, vt[k].e_rdy);
      if (vt[k].e_rdy) chk($sformatf("vec%0d_err", k), dbg_err, vt[k].e_err);
      zero_in();
      tick;
    end

    // CPU store of 0xDEADBEEF at 0x10, then debug read it back
    cpu_we = 1; cpu_wr_addr = 32'h10; cpu_wr_data = 32'hDEADBEEF;
    tick;
    zero_in();
    set_dbg(0, 32'h10, 3'd2, '0);
    #1;
    chk("rd_ready", dbg_ready, 1);
    chk("rd_mem_re", mem_re, 1);
    chk("rd_addr", mem_rd_addr, 32'h10);
    tick;
    dbg_valid = 0;
    chk("rd_rvalid", dbg_rvalid, 1);
    chk("rd_rdata", dbg_rdata, 32'hDEADBEEF);
    chk("rd_err", dbg_err, 0);
    tick;
    chk("rd_rvalid_off", dbg_rvalid, 0);
    chk("rd_rdata_hold", dbg_rdata, 32'hDEADBEEF);

    // Starvation: CPU reads continuously, debug write waits exactly LIM cycles
    cpu_re = 1; cpu_rd_addr = 32'h0;
    set_dbg(1, 32'h20, 3'd2, 32'h12345678);
    for (int c = 0; c < LIM; c++) begin
      #1;
      chk($sformatf("starve_blk%0d_ready", c), dbg_ready, 0);
      chk($sformatf("starve_blk%0d_stall", c), cpu_stall, 0);
      tick;
    end
    #1;
    chk("starve_ready", dbg_ready, 1);
    chk("starve_stall", cpu_stall, 1);
    chk("starve_mem_we", mem_we, 1);
    chk("starve_mem_re", mem_re, 0);
    tick;
    dbg_valid = 0;
    #1;
    chk("starve_after_stall", cpu_stall, 0);
    chk("starve_rvalid", dbg_rvalid, 1);
    chk("starve_rdata_wr", dbg_rdata, 0);
    tick;
    zero_in();
    dbg_read_expect("starve_rb", 32'h20, 32'h12345678);

    // Misaligned write is accepted, flagged, and does not touch memory
    set_dbg(1, 32'h22, 3'd2, 32'hFFFFFFFF);
    #1;
    chk("mis_ready", dbg_ready, 1);
    chk("mis_mem_we", mem_we, 0);
    tick;
    dbg_valid = 0;
    chk("mis_rvalid", dbg_rvalid, 1);
    chk("mis_err", dbg_err, 1);
    tick;
    chk("mis_err_hold", dbg_err, 1);
    dbg_read_expect("mis_rb", 32'h20, 32'h12345678);
    chk("good_err_clear", dbg_err, 0);
    // Oversize (16B on a 32-bit port)
    set_dbg(0, 32'h0, 3'd4, '0);
    #1;
    chk("big_ready", dbg_ready, 1);
    chk("big_mem_re", mem_re, 0);
    tick;
    dbg_valid = 0;
    chk("big_err", dbg_err, 1);
    chk("big_rdata", dbg_rdata, 0);
    tick;

    // mem_must_wait freezes the counter: 2 blocked, 3 frozen, 2 blocked, grant
    cpu_we = 1; cpu_wr_addr = 32'h40; cpu_wr_data = 32'h55AA55AA;
    set_dbg(0, 32'h20, 3'd2, '0);
    for (int c = 0; c < 7; c++) begin
      mem_must_wait = (c >= 2 && c < 5);
      #1;
      chk($sformatf("mw%0d_ready", c), dbg_ready, 0);
      chk($sformatf("mw%0d_stall", c), cpu_stall, mem_must_wait);
      tick;
    end
    #1;
    chk("mw_grant", dbg_ready, 1);
    chk("mw_grant_stall", cpu_stall, 1);
    chk("mw_grant_we", mem_we, 0);
    tick;
    zero_in();
    chk("mw_rdata", dbg_rdata, 32'h12345678);
    tick;

    // Reset during RESP drops the response
    set_dbg(0, 32'h10, 3'd2, '0);
    tick;
    chk("rr_rvalid", dbg_rvalid, 1);
    chk("rr_rdata", dbg_rdata, 32'hDEADBEEF);
    cpu_re = 1;
    clr_n = 0;
    #1;
    chk("rr_rvalid_async", dbg_rvalid, 0);
    chk("rr_rdata_async", dbg_rdata, 0);
    chk("rr_err_async", dbg_err, 0);
    chk("rr_ready", dbg_ready, 0);
    chk("rr_mem_re", mem_re, 0);
    chk("rr_stall", cpu_stall, 1);
    tick;
    zero_in();
    clr_n = 1;
    #1 chk("rr_rel_stall", cpu_stall, 0);
    tick;
    chk("rr_no_pulse", dbg_rvalid, 0);
    mem_must_wait = 1;
    #1 chk("rr_mw_stall", cpu_stall, 1);
    mem_must_wait = 0;
    tick;

    // Back-to-back debug requests: grants on alternate cycles
    set_dbg(0, 32'h10, 3'd2, '0);
    for (int c = 0; c < 6; c++) begin
      #1 chk($sformatf("b2b%0d_ready", c), dbg_ready, (c % 2) == 0);
      tick;
      chk($sformatf("b2b%0d_rvalid", c), dbg_rvalid, (c % 2) == 0);
      if ((c % 2) == 0) chk($sformatf("b2b%0d_rdata", c), dbg_rdata, 32'hDEADBEEF);
    end
    zero_in();
    tick;

    // Randomized traffic against the behavioural model
    clr_n = 0;
    tick;
    clr_n = 1;
    m_resp = 0; m_blk = 0; m_last_rd = '0; m_last_err = 0; m_grant = 0;
    m_exp_rd = '0; m_exp_err = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      int cb, db, a;
      cb = $urandom_range(0, 2);
      cpu_re = ($urandom % 3) == 0;
      cpu_we = ($urandom % 4) == 0;
      cpu_rd_bytes = 3'(cb); cpu_wr_bytes = 3'(cb);
      cpu_rd_addr = 32'(($urandom_range(0, 255) >> cb) << cb);
      cpu_wr_addr = 32'(($urandom_range(0, 255) >> cb) << cb);
      cpu_wr_data = $urandom; cpu_rd_unsigned = $urandom_range(0, 1) == 1;
      mem_must_wait = ($urandom % 8) == 0;
      if (!dbg_valid || m_grant || ($urandom % 8) == 0) begin
        db = $urandom_range(0, 4);
        a = $urandom_range(0, 255);
        if ($urandom_range(0, 1) == 1 && db <= 2) a = (a >> db) << db;
        dbg_valid = ($urandom % 3) != 0;
        dbg_write = $urandom_range(0, 1) == 1;
        dbg_bytes = 3'(db); dbg_addr = 32'(a);
        dbg_wdata = $urandom; dbg_unsigned = $urandom_range(0, 1) == 1;
      end
      m_cpu   = cpu_re || cpu_we;
      m_err   = (dbg_bytes > 2) || ((int'(dbg_addr[7:0]) % (1 << dbg_bytes)) != 0);
      m_grant = !m_resp && dbg_valid && !mem_must_wait && (!m_cpu || m_blk >= LIM);
      m_good  = m_grant && !dbg_write && !m_err;
      m_exp_re = m_grant ? m_good : cpu_re;
      m_exp_we = m_grant ? (dbg_write && !m_err) : cpu_we;
      #1;
      chk("rnd_ready", dbg_ready, m_grant);
      chk("rnd_stall", cpu_stall, mem_must_wait || (m_grant && m_cpu));
      chk("rnd_mem_re", mem_re, m_exp_re);
      chk("rnd_mem_we", mem_we, m_exp_we);
      if (m_exp_re) chk("rnd_rd_addr", mem_rd_addr, m_grant ? dbg_addr : cpu_rd_addr);
      if (m_exp_we) chk("rnd_wr_data", mem_wr_data, m_grant ? dbg_wdata : cpu_wr_data);
      if (m_grant) begin
        m_exp_rd  = m_good ? ld(dbg_addr, dbg_bytes, dbg_unsigned) : '0;
        m_exp_err = m_err;
      end
      if (!dbg_valid || m_grant) m_blk = 0;
      else if (!mem_must_wait && m_cpu && m_blk < LIM) m_blk++;
      tick;
      chk("rnd_rvalid", dbg_rvalid, m_grant);
      if (m_grant) begin
        m_last_rd = m_exp_rd;
        m_last_err = m_exp_err;
      end
      chk("rnd_rdata", dbg_rdata, m_last_rd);
      chk("rnd_err", dbg_err, m_last_err);
      m_resp = m_grant;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
